// File: rtl/bp_addr_map_router.sv
// rtl/bp_addr_map_router.sv - physical address decode to DRAM/device/coproc channels with per-channel outstanding limits
module bp_addr_map_router #(
  parameter int paddr_width_p     = 40,
  parameter int data_width_p      = 64,
  parameter int num_dev_p         = 3,
  parameter int dev_lsb_p         = 20,
  parameter int max_outstanding_p = 4,
  localparam int num_chan         = num_dev_p + 2,
  localparam int cw               = $clog2(num_chan)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     cmd_v_i,
  output logic                     cmd_ready_o,
  input  logic [paddr_width_p-1:0] cmd_addr_i,
  input  logic [data_width_p-1:0]  cmd_data_i,
  input  logic                     cmd_wr_i,
  output logic                     out_v_o,
  output logic [cw-1:0]            out_chan_o,
  output logic [paddr_width_p-1:0] out_addr_o,
  output logic [data_width_p-1:0]  out_data_o,
  output logic                     out_wr_o,
  input  logic [num_chan-1:0]      out_ready_i,
  input  logic [num_chan-1:0]      done_i,
  output logic                     err_v_o,
  output logic [paddr_width_p-1:0] err_addr_o,
  input  logic                     err_ready_i,
  output logic [num_chan-1:0]      pend_o
);

  localparam int cntw = $clog2(max_outstanding_p + 1);
  localparam logic [cntw-1:0] max_cnt   = cntw'(max_outstanding_p);
  localparam logic [3:0]      num_dev_l = 4'(num_dev_p);

  logic                     slot_v_q, slot_v_d;
  logic [cw-1:0]            slot_chan_q, slot_chan_d;
  logic [paddr_width_p-1:0] slot_addr_q, slot_addr_d;
  logic [data_width_p-1:0]  slot_data_q, slot_data_d;
  logic                     slot_wr_q, slot_wr_d;
  logic                     err_v_q, err_v_d;
  logic [paddr_width_p-1:0] err_addr_q, err_addr_d;
  logic [cntw-1:0]          cnt_q [num_chan];
  logic [cntw-1:0]          cnt_d [num_chan];

  logic [63:0]   addr_ext;
  logic [3:0]    dev_fld;
  logic          dec_mapped;
  logic [cw-1:0] dec_chan;
  logic [cntw-1:0] sel_cnt;
  logic          sel_rdy;
  logic          out_fire, err_fire, accept;

  assign addr_ext = 64'(cmd_addr_i);
  assign dev_fld  = addr_ext[dev_lsb_p +: 4];

  // Coproc/global space wins first, then DRAM, then the small device window below 16 MiB.
  always_comb begin
    dec_mapped = 1'b1;
    dec_chan   = '0;
    if (addr_ext >= 64'h10_0000_0000) begin
      dec_chan = cw'(num_dev_p + 1);
    end else if (addr_ext >= 64'h8000_0000) begin
      dec_chan = '0;
    end else if (addr_ext[31:24] == 8'h00 && dev_fld != 4'd0 && dev_fld <= num_dev_l) begin
      dec_chan = cw'(dev_fld);
    end else begin
      dec_mapped = 1'b0;
    end
  end

  always_comb begin
    sel_cnt = '0;
    sel_rdy = 1'b0;
    for (int c = 0; c < num_chan; c++) begin
      if (slot_chan_q == cw'(c)) begin
        sel_cnt = cnt_q[c];
        sel_rdy = out_ready_i[c];
      end
    end
  end

  assign out_v_o     = slot_v_q & (sel_cnt < max_cnt);
  assign out_fire    = out_v_o & sel_rdy;
  assign err_fire    = err_v_q & err_ready_i;
  assign cmd_ready_o = (~slot_v_q | out_fire) & (~err_v_q | err_fire);
  assign accept      = cmd_v_i & cmd_ready_o;

  always_comb begin
    slot_v_d    = slot_v_q & ~out_fire;
    slot_chan_d = slot_chan_q;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    slot_wr_d   = slot_wr_q;
    err_v_d     = err_v_q & ~err_fire;
    err_addr_d  = err_addr_q;
    if (accept && dec_mapped) begin
      slot_v_d    = 1'b1;
      slot_chan_d = dec_chan;
      slot_addr_d = cmd_addr_i;
      slot_data_d = cmd_data_i;
      slot_wr_d   = cmd_wr_i;
    end else if (accept) begin
      err_v_d    = 1'b1;
      err_addr_d = cmd_addr_i;
    end
  end

  // A completion on an idle channel is dropped rather than wrapping the counter.
  always_comb begin
    for (int c = 0; c < num_chan; c++) begin
      cnt_d[c] = cnt_q[c];
      if ((out_fire && slot_chan_q == cw'(c)) && !(done_i[c] && cnt_q[c] != '0)) begin
        cnt_d[c] = cnt_q[c] + cntw'(1);
      end else if (!(out_fire && slot_chan_q == cw'(c)) && (done_i[c] && cnt_q[c] != '0)) begin
        cnt_d[c] = cnt_q[c] - cntw'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      slot_v_q    <= 1'b0;
      slot_chan_q <= '0;
      slot_addr_q <= '0;
      slot_data_q <= '0;
      slot_wr_q   <= 1'b0;
      err_v_q     <= 1'b0;
      err_addr_q  <= '0;
      for (int c = 0; c < num_chan; c++) cnt_q[c] <= '0;
    end else begin
      slot_v_q    <= slot_v_d;
      slot_chan_q <= slot_chan_d;
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
      slot_wr_q   <= slot_wr_d;
      err_v_q     <= err_v_d;
      err_addr_q  <= err_addr_d;
      for (int c = 0; c < num_chan; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  always_comb begin
    pend_o = '0;
    for (int c = 0; c < num_chan; c++) pend_o[c] = (cnt_q[c] != '0);
  end

  assign out_chan_o = slot_chan_q;
  assign out_addr_o = slot_addr_q;
  assign out_data_o = slot_data_q;
  assign out_wr_o   = slot_wr_q;
  assign err_v_o    = err_v_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_bp_addr_map_router.sv
// tb/tb_bp_addr_map_router.sv - directed plus randomized checks of the router against a behavioural model
module tb_bp_addr_map_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_v;
  logic        cmd_ready;
  logic [39:0] cmd_addr;
  logic [63:0] cmd_data;
  logic        cmd_wr;
  logic        out_v;
  logic [2:0]  out_chan;
  logic [39:0] out_addr;
  logic [63:0] out_data;
  logic        out_wr;
  logic [4:0]  out_ready;
  logic [4:0]  done;
  logic        err_v;
  logic [39:0] err_addr;
  logic        err_ready;
  logic [4:0]  pend;

  int tests = 0;
  int fails = 0;

  // model state
  int          m_cnt [5];
  bit          m_sv;
  int          m_sch;
  logic [39:0] m_sa;
  logic [63:0] m_sd;
  bit          m_sw;
  bit          m_ev;
  logic [39:0] m_ea;
  // model next state
  int          n_cnt [5];
  bit          n_sv, n_sw, n_ev;
  int          n_sch;
  logic [39:0] n_sa, n_ea;
  logic [63:0] n_sd;

  bp_addr_map_router dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .cmd_data_i(cmd_data), .cmd_wr_i(cmd_wr),
    .out_v_o(out_v), .out_chan_o(out_chan), .out_addr_o(out_addr),
    .out_data_o(out_data), .out_wr_o(out_wr), .out_ready_i(out_ready),
    .done_i(done), .err_v_o(err_v), .err_addr_o(err_addr),
    .err_ready_i(err_ready), .pend_o(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -1 means unmapped; otherwise the target channel number.
  function automatic int decode(input logic [39:0] a);
    longint unsigned x = 64'(a);
    int d;
    if (x >= 64'h10_0000_0000) return 4;
    if (x >= 64'h8000_0000) return 0;
    if (x < 64'h100_0000) begin
      d = int'((x >> 20) & 64'hf);
      if (d >= 1 && d <= 3) return d;
    end
    return -1;
  endfunction

  function automatic logic [4:0] model_pend();
    logic [4:0] p = '0;
    for (int c = 0; c < 5; c++) p[c] = (m_cnt[c] != 0);
    return p;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 5; c++) m_cnt[c] = 0;
    m_sv = 0; m_ev = 0; m_sch = 0; m_sa = '0; m_sd = '0; m_sw = 0; m_ea = '0;
  endtask

  // Compare outputs against the model with the current inputs, then compute the post-edge state.
  task automatic model_step();
    bit e_ov, fire, efire, e_rdy, acc;
    int ch;
    e_ov  = m_sv && (m_cnt[m_sch] < 4);
    fire  = e_ov && out_ready[m_sch];
    efire = m_ev && err_ready;
    e_rdy = (!m_sv || fire) && (!m_ev || efire);
    acc   = cmd_v && e_rdy;
    chk("out_v", 64'(out_v), 64'(e_ov));
    chk("cmd_ready", 64'(cmd_ready), 64'(e_rdy));
    chk("err_v", 64'(err_v), 64'(m_ev));
    chk("pend", 64'(pend), 64'(model_pend()));
    if (e_ov) begin
      chk("out_chan", 64'(out_chan), 64'(m_sch));
      chk("out_addr", 64'(out_addr), 64'(m_sa));
      chk("out_data", out_data, m_sd);
      chk("out_wr", 64'(out_wr), 64'(m_sw));
    end
    if (m_ev) chk("err_addr", 64'(err_addr), 64'(m_ea));
    for (int c = 0; c < 5; c++) begin
      n_cnt[c] = m_cnt[c];
      if (fire && m_sch == c) n_cnt[c]++;
      if (done[c] && m_cnt[c] > 0) n_cnt[c]--;
    end
    n_sv = m_sv; n_sch = m_sch; n_sa = m_sa; n_sd = m_sd; n_sw = m_sw;
    n_ev = m_ev && !efire; n_ea = m_ea;
    ch = decode(cmd_addr);
    if (acc && ch >= 0) begin
      n_sv = 1; n_sch = ch; n_sa = cmd_addr; n_sd = cmd_data; n_sw = cmd_wr;
    end else if (fire) begin
      n_sv = 0;
    end
    if (acc && ch < 0) begin
      n_ev = 1; n_ea = cmd_addr;
    end
  endtask

  task automatic cycle(input bit v, input logic [39:0] a, input logic [63:0] d, input bit wr,
                       input logic [4:0] rdy, input logic [4:0] dn, input bit erdy);
    @(negedge clk);
    cmd_v = v; cmd_addr = a; cmd_data = d; cmd_wr = wr;
    out_ready = rdy; done = dn; err_ready = erdy;
    #1;
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) m_cnt[c] = n_cnt[c];
    m_sv = n_sv; m_sch = n_sch; m_sa = n_sa; m_sd = n_sd; m_sw = n_sw;
    m_ev = n_ev; m_ea = n_ea;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_v", 64'(out_v), 64'd0);
    chk("rst_err_v", 64'(err_v), 64'd0);
    chk("rst_pend", 64'(pend), 64'd0);
    model_reset();
    @(negedge clk);
    cmd_v = 0; done = '0;
    rst_n = 1'b1;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  function automatic logic [39:0] rand_addr();
    longint unsigned r = {$urandom(), $urandom()};
    case ($urandom_range(0, 4))
      0: return 40'(64'h8000_0000 + r % (64'h10_0000_0000 - 64'h8000_0000));
      1: return 40'(64'h10_0000_0000 + r % (64'h100_0000_0000 - 64'h10_0000_0000));
      2: return 40'(((r >> 32) & 64'hf) << 20 | (r & 64'hf_ffff));
      3: return 40'(64'h100_0000 + r % (64'h8000_0000 - 64'h100_0000));
      default: return 40'(r);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    cmd_v = 0; cmd_addr = '0; cmd_data = '0; cmd_wr = 0;
    out_ready = '0; done = '0; err_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("init_out_v", 64'(out_v), 64'd0);
    chk("init_err_v", 64'(err_v), 64'd0);
    chk("init_pend", 64'(pend), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("init_cmd_ready", 64'(cmd_ready), 64'd1);

    // DRAM read, issue, then completion
    cycle(1, 40'h8000_1000, 64'h1234, 0, 5'h1f, 5'h00, 1);
    chk("dram_out_v", 64'(out_v), 64'd1);
    chk("dram_chan", 64'(out_chan), 64'd0);
    chk("dram_addr", 64'(out_addr), 64'h8000_1000);
    cycle(0, '0, '0, 0, 5'h1f, 5'h00, 1);
    chk("dram_pend", 64'(pend), 64'h01);
    cycle(0, '0, '0, 0, 5'h1f, 5'h01, 1);
    chk("dram_pend_clr", 64'(pend), 64'h00);

    // device window and unmapped device
    do_reset();
    cycle(1, 40'h0020_0040, 64'hab, 1, 5'h1f, 5'h00, 0);
    chk("dev2_chan", 64'(out_chan), 64'd2);
    chk("dev2_v", 64'(out_v), 64'd1);
    cycle(1, 40'h0050_0000, 64'h0, 0, 5'h1f, 5'h00, 0);
    chk("dev5_err_v", 64'(err_v), 64'd1);
    chk("dev5_err_addr", 64'(err_addr), 64'h50_0000);
    chk("dev5_no_out", 64'(out_v), 64'd0);
    cycle(0, '0, '0, 0, 5'h1f, 5'h00, 1);
    chk("dev5_err_clr", 64'(err_v), 64'd0);

    // coproc/global space
    do_reset();
    cycle(1, 40'h10_0000_0000, 64'h1, 0, 5'h1f, 5'h00, 1);
    chk("cop_chan_a", 64'(out_chan), 64'd4);
    cycle(1, 40'h20_0000_0008, 64'h2, 1, 5'h1f, 5'h00, 1);
    chk("cop_chan_b", 64'(out_chan), 64'd4);
    chk("cop_v_b", 64'(out_v), 64'd1);

    // outstanding limit of four on DRAM
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 40'h8000_0000, 64'(i), 0, 5'h01, 5'h00, 1);
    chk("lim_out_v", 64'(out_v), 64'd0);
    chk("lim_pend", 64'(pend), 64'h01);
    cycle(0, '0, '0, 0, 5'h01, 5'h00, 1);
    chk("lim_cmd_ready", 64'(cmd_ready), 64'd0);
    cycle(0, '0, '0, 0, 5'h01, 5'h01, 1);
    chk("lim_release_v", 64'(out_v), 64'd1);
    cycle(0, '0, '0, 0, 5'h01, 5'h00, 1);
    chk("lim_issued", 64'(out_v), 64'd0);
    chk("lim_ready_again", 64'(cmd_ready), 64'd1);

    // simultaneous issue and done, and done on an idle channel
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 40'h8000_0000, 64'(i), 0, 5'h01, 5'h00, 1);
    cycle(0, '0, '0, 0, 5'h01, 5'h01, 1);
    chk("same_cyc_pend", 64'(pend), 64'h01);
    cycle(0, '0, '0, 0, 5'h01, 5'h01, 1);
    chk("cnt_one_pend", 64'(pend), 64'h01);
    cycle(0, '0, '0, 0, 5'h01, 5'h01, 1);
    chk("cnt_zero_pend", 64'(pend), 64'h00);
    cycle(0, '0, '0, 0, 5'h01, 5'h02, 1);
    chk("idle_done_pend", 64'(pend), 64'h00);

    // reset with a slot held, then with an error held, then normal routing
    do_reset();
    cycle(1, 40'h8000_0000, 64'h5, 0, 5'h00, 5'h00, 0);
    chk("hold_slot_v", 64'(out_v), 64'd1);
    do_reset();
    cycle(1, 40'h0100_0000, 64'h6, 0, 5'h00, 5'h00, 0);
    chk("hold_err_v", 64'(err_v), 64'd1);
    do_reset();
    cycle(1, 40'h8000_1000, 64'h7, 1, 5'h1f, 5'h00, 1);
    chk("post_rst_chan", 64'(out_chan), 64'd0);
    chk("post_rst_v", 64'(out_v), 64'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rdy, dn;
      for (int c = 0; c < 5; c++) begin
        rdy[c] = ($urandom_range(0, 3) != 0);
        dn[c]  = ($urandom_range(0, 9) < 3);
      end
      cycle($urandom_range(0, 9) < 7, rand_addr(), {$urandom(), $urandom()}, 1'($urandom()),
            rdy, dn, $urandom_range(0, 9) < 6);
      if (i == 1500) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
